// File: rtl/eth_fcs_checker_pkg.sv
// Shared constants, FSM state type and the byte-wise reflected CRC-32 step
// used by the Ethernet FCS checker.
package eth_fcs_checker_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  localparam int unsigned ETH_MIN_FRAME = 64;
  localparam int unsigned ETH_MAX_FRAME = 1522;

  typedef enum logic [1:0] {IDLE, BODY, DROP} fcs_state_t;

  // One byte through the LSB-first CRC-32, without final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_fcs_checker_crc.sv
// Combinational multi-byte CRC-32 step: applies the enabled bytes of one beat
// in wire order (byte 0 first).
module eth_fcs_checker_crc
  import eth_fcs_checker_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4
) (
  input  logic [31:0]             crc_in,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [DATA_BYTES-1:0]   keep,
  output logic [31:0]             crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (keep[i]) begin
        crc_out = crc32_byte(crc_out, data[8*i +: 8]);
      end
    end
  end

endmodule

// File: rtl/eth_fcs_checker.sv
// Ethernet RX FCS checker: forwards the beat stream one cycle later, reports
// per-frame status on the forwarded last beat and keeps saturating statistics.
module eth_fcs_checker
  import eth_fcs_checker_pkg::*;
#(
  parameter int unsigned DATA_BYTES      = 4,
  parameter int unsigned MIN_FRAME_BYTES = ETH_MIN_FRAME,
  parameter int unsigned MAX_FRAME_BYTES = ETH_MAX_FRAME,
  parameter int unsigned LEN_W           = 16,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [8*DATA_BYTES-1:0] s_tdata,
  input  logic [DATA_BYTES-1:0]   s_tkeep,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  input  logic                    s_tabort,
  output logic [8*DATA_BYTES-1:0] m_tdata,
  output logic [DATA_BYTES-1:0]   m_tkeep,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  output logic                    m_tuser,
  output logic                    frame_done,
  output logic                    frame_good,
  output logic                    crc_err,
  output logic                    len_err,
  output logic                    abort_err,
  output logic                    keep_err,
  output logic [LEN_W-1:0]        frame_len,
  output logic [CNT_W-1:0]        good_cnt,
  output logic [CNT_W-1:0]        bad_cnt
);

  localparam logic [LEN_W:0] MinLen = (LEN_W+1)'(MIN_FRAME_BYTES);
  localparam logic [LEN_W:0] MaxLen = (LEN_W+1)'(MAX_FRAME_BYTES);

  fcs_state_t       state_q;
  logic [31:0]      crc_q, crc_beat;
  logic [LEN_W-1:0] len_q, len_next;
  logic             abort_q, keep_err_q;

  logic [3:0]            keep_cnt;
  logic [LEN_W:0]        len_sum;
  logic [DATA_BYTES:0]   keep_inc;
  logic                  keep_bad, crc_bad, len_bad, abort_all, keep_all, frame_bad;

  eth_fcs_checker_crc #(
    .DATA_BYTES (DATA_BYTES)
  ) u_crc (
    .crc_in  (crc_q),
    .data    (s_tdata),
    .keep    (s_tkeep),
    .crc_out (crc_beat)
  );

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      keep_cnt = keep_cnt + 4'(s_tkeep[i]);
    end
    len_sum  = {1'b0, len_q} + (LEN_W+1)'(keep_cnt);
    len_next = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

    // LSB-packed keep has no set bit above a clear one: keep & (keep + 1) == 0.
    keep_inc = {1'b0, s_tkeep} + (DATA_BYTES+1)'(1);
    if (s_tlast) begin
      keep_bad = (s_tkeep == '0) || ((keep_inc & {1'b0, s_tkeep}) != '0);
    end else begin
      keep_bad = (s_tkeep != '1);
    end

    abort_all = abort_q | s_tabort;
    keep_all  = keep_err_q | keep_bad;
    crc_bad   = (crc_beat != CRC32_RESIDUE);
    len_bad   = ((MIN_FRAME_BYTES != 0) && ({1'b0, len_next} < MinLen)) ||
                ({1'b0, len_next} > MaxLen);
    frame_bad = crc_bad | len_bad | abort_all | keep_all;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      crc_q      <= CRC32_INIT;
      len_q      <= '0;
      abort_q    <= 1'b0;
      keep_err_q <= 1'b0;
      m_tdata    <= '0;
      m_tkeep    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      m_tuser    <= 1'b0;
      frame_done <= 1'b0;
      frame_good <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      abort_err  <= 1'b0;
      keep_err   <= 1'b0;
      frame_len  <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      m_tdata    <= s_tdata;
      m_tkeep    <= s_tkeep;
      m_tvalid   <= s_tvalid;
      m_tlast    <= s_tvalid & s_tlast;
      m_tuser    <= 1'b0;
      frame_done <= 1'b0;
      if (s_tvalid) begin
        if (s_tlast) begin
          // Frame ends: publish status and rearm for the next frame start.
          state_q    <= IDLE;
          crc_q      <= CRC32_INIT;
          len_q      <= '0;
          abort_q    <= 1'b0;
          keep_err_q <= 1'b0;
          m_tuser    <= frame_bad;
          frame_done <= 1'b1;
          frame_good <= ~frame_bad;
          crc_err    <= crc_bad;
          len_err    <= len_bad;
          abort_err  <= abort_all;
          keep_err   <= keep_all;
          frame_len  <= len_next;
          if (frame_bad) begin
            if (bad_cnt != '1) bad_cnt <= bad_cnt + CNT_W'(1);
          end else begin
            if (good_cnt != '1) good_cnt <= good_cnt + CNT_W'(1);
          end
        end else begin
          crc_q      <= crc_beat;
          len_q      <= len_next;
          abort_q    <= abort_all;
          keep_err_q <= keep_all;
          unique case (state_q)
            IDLE:    state_q <= BODY;
            BODY:    if (s_tabort) state_q <= DROP;
            DROP:    state_q <= DROP;
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_fcs_checker.sv
// Directed bench for eth_fcs_checker across four parameter sets sharing one clock and reset.
module tb_eth_fcs_checker;

  typedef logic [7:0] q_t[$];

  typedef struct {
    int         ndone;
    int         nbytes;
    logic       good, crc, len, abort, keep, tuser;
    logic [15:0] flen;
  } stat_t;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic areset = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance 0: DATA_BYTES=1, MIN=0
  logic [7:0]  s_tdata_0, m_tdata_0;
  logic        s_tkeep_0, m_tkeep_0;
  logic        s_tvalid_0 = 0, s_tlast_0 = 0, s_tabort_0 = 0;
  logic        m_tvalid_0, m_tlast_0, m_tuser_0, done_0, fgood_0, crc_0, len_0, abort_0, keep_0;
  logic [15:0] flen_0;
  logic [31:0] gcnt_0, bcnt_0;
  // Instance 1: DATA_BYTES=4, MIN=0
  logic [31:0] s_tdata_1, m_tdata_1;
  logic [3:0]  s_tkeep_1, m_tkeep_1;
  logic        s_tvalid_1 = 0, s_tlast_1 = 0, s_tabort_1 = 0;
  logic        m_tvalid_1, m_tlast_1, m_tuser_1, done_1, fgood_1, crc_1, len_1, abort_1, keep_1;
  logic [15:0] flen_1;
  logic [31:0] gcnt_1, bcnt_1;
  // Instance 2: defaults
  logic [31:0] s_tdata_2, m_tdata_2;
  logic [3:0]  s_tkeep_2, m_tkeep_2;
  logic        s_tvalid_2 = 0, s_tlast_2 = 0, s_tabort_2 = 0;
  logic        m_tvalid_2, m_tlast_2, m_tuser_2, done_2, fgood_2, crc_2, len_2, abort_2, keep_2;
  logic [15:0] flen_2;
  logic [31:0] gcnt_2, bcnt_2;
  // Instance 3: DATA_BYTES=8
  logic [63:0] s_tdata_3, m_tdata_3;
  logic [7:0]  s_tkeep_3, m_tkeep_3;
  logic        s_tvalid_3 = 0, s_tlast_3 = 0, s_tabort_3 = 0;
  logic        m_tvalid_3, m_tlast_3, m_tuser_3, done_3, fgood_3, crc_3, len_3, abort_3, keep_3;
  logic [15:0] flen_3;
  logic [31:0] gcnt_3, bcnt_3;

  eth_fcs_checker #(.DATA_BYTES(1), .MIN_FRAME_BYTES(0)) u0 (
    .aclk(aclk), .areset(areset), .s_tdata(s_tdata_0), .s_tkeep(s_tkeep_0),
    .s_tvalid(s_tvalid_0), .s_tlast(s_tlast_0), .s_tabort(s_tabort_0), .m_tdata(m_tdata_0),
    .m_tkeep(m_tkeep_0), .m_tvalid(m_tvalid_0), .m_tlast(m_tlast_0), .m_tuser(m_tuser_0),
    .frame_done(done_0), .frame_good(fgood_0), .crc_err(crc_0), .len_err(len_0),
    .abort_err(abort_0), .keep_err(keep_0), .frame_len(flen_0), .good_cnt(gcnt_0),
    .bad_cnt(bcnt_0));
  eth_fcs_checker #(.DATA_BYTES(4), .MIN_FRAME_BYTES(0)) u1 (
    .aclk(aclk), .areset(areset), .s_tdata(s_tdata_1), .s_tkeep(s_tkeep_1),
    .s_tvalid(s_tvalid_1), .s_tlast(s_tlast_1), .s_tabort(s_tabort_1), .m_tdata(m_tdata_1),
    .m_tkeep(m_tkeep_1), .m_tvalid(m_tvalid_1), .m_tlast(m_tlast_1), .m_tuser(m_tuser_1),
    .frame_done(done_1), .frame_good(fgood_1), .crc_err(crc_1), .len_err(len_1),
    .abort_err(abort_1), .keep_err(keep_1), .frame_len(flen_1), .good_cnt(gcnt_1),
    .bad_cnt(bcnt_1));
  eth_fcs_checker u2 (
    .aclk(aclk), .areset(areset), .s_tdata(s_tdata_2), .s_tkeep(s_tkeep_2),
    .s_tvalid(s_tvalid_2), .s_tlast(s_tlast_2), .s_tabort(s_tabort_2), .m_tdata(m_tdata_2),
    .m_tkeep(m_tkeep_2), .m_tvalid(m_tvalid_2), .m_tlast(m_tlast_2), .m_tuser(m_tuser_2),
    .frame_done(done_2), .frame_good(fgood_2), .crc_err(crc_2), .len_err(len_2),
    .abort_err(abort_2), .keep_err(keep_2), .frame_len(flen_2), .good_cnt(gcnt_2),
    .bad_cnt(bcnt_2));
  eth_fcs_checker #(.DATA_BYTES(8)) u3 (
    .aclk(aclk), .areset(areset), .s_tdata(s_tdata_3), .s_tkeep(s_tkeep_3),
    .s_tvalid(s_tvalid_3), .s_tlast(s_tlast_3), .s_tabort(s_tabort_3), .m_tdata(m_tdata_3),
    .m_tkeep(m_tkeep_3), .m_tvalid(m_tvalid_3), .m_tlast(m_tlast_3), .m_tuser(m_tuser_3),
    .frame_done(done_3), .frame_good(fgood_3), .crc_err(crc_3), .len_err(len_3),
    .abort_err(abort_3), .keep_err(keep_3), .frame_len(flen_3), .good_cnt(gcnt_3),
    .bad_cnt(bcnt_3));

  // Output monitors: collect per-instance frame status on the falling edge.
  stat_t st0, st1, st2, st3;

  function automatic stat_t upd(input stat_t s, input logic rst, input logic mv,
                                input logic [7:0] mk, input logic d, input logic tu,
                                input logic g, input logic c, input logic l, input logic a,
                                input logic k, input logic [15:0] fl);
    stat_t r;
    r = s;
    if (rst) begin
      r.ndone = 0; r.nbytes = 0; r.good = 0; r.crc = 0; r.len = 0;
      r.abort = 0; r.keep = 0; r.tuser = 0; r.flen = '0;
    end else begin
      if (mv) for (int i = 0; i < 8; i++) r.nbytes += int'(mk[i]);
      if (d) begin
        r.ndone++; r.good = g; r.crc = c; r.len = l; r.abort = a; r.keep = k;
        r.tuser = tu; r.flen = fl;
      end
    end
    return r;
  endfunction

  always @(negedge aclk) st0 = upd(st0, areset, m_tvalid_0, {7'b0, m_tkeep_0}, done_0,
                                   m_tuser_0, fgood_0, crc_0, len_0, abort_0, keep_0, flen_0);
  always @(negedge aclk) st1 = upd(st1, areset, m_tvalid_1, {4'b0, m_tkeep_1}, done_1,
                                   m_tuser_1, fgood_1, crc_1, len_1, abort_1, keep_1, flen_1);
  always @(negedge aclk) st2 = upd(st2, areset, m_tvalid_2, {4'b0, m_tkeep_2}, done_2,
                                   m_tuser_2, fgood_2, crc_2, len_2, abort_2, keep_2, flen_2);
  always @(negedge aclk) st3 = upd(st3, areset, m_tvalid_3, m_tkeep_3, done_3,
                                   m_tuser_3, fgood_3, crc_3, len_3, abort_3, keep_3, flen_3);

  // Bit-serial reference FCS (value as transmitted, already inverted).
  function automatic logic [31:0] model_fcs(input q_t p);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    foreach (p[i]) begin
      b = p[i];
      for (int j = 0; j < 8; j++) c = (c >> 1) ^ ((c[0] ^ b[j]) ? 32'hEDB8_8320 : 32'h0);
    end
    return ~c;
  endfunction

  function automatic q_t add_fcs(input q_t p);
    q_t r;
    logic [31:0] f;
    r = p;
    f = model_fcs(p);
    for (int i = 0; i < 4; i++) r.push_back(f[8*i +: 8]);
    return r;
  endfunction

  task automatic set_in(input int k, input logic [63:0] d, input logic [7:0] kp,
                        input logic v, input logic l, input logic a);
    case (k)
      0: begin s_tdata_0 = d[7:0];  s_tkeep_0 = kp[0];   s_tvalid_0 = v; s_tlast_0 = l; s_tabort_0 = a; end
      1: begin s_tdata_1 = d[31:0]; s_tkeep_1 = kp[3:0]; s_tvalid_1 = v; s_tlast_1 = l; s_tabort_1 = a; end
      2: begin s_tdata_2 = d[31:0]; s_tkeep_2 = kp[3:0]; s_tvalid_2 = v; s_tlast_2 = l; s_tabort_2 = a; end
      default: begin s_tdata_3 = d; s_tkeep_3 = kp; s_tvalid_3 = v; s_tlast_3 = l; s_tabort_3 = a; end
    endcase
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_frame(input int k, input int db, input q_t fr, input int abort_beat,
                            input bit gaps, input bit no_last);
    int nb;
    logic [63:0] d;
    logic [7:0]  kp;
    nb = (fr.size() + db - 1) / db;
    for (int b = 0; b < nb; b++) begin
      if (gaps && (b % 3 == 2)) begin
        set_in(k, '0, '0, 1'b0, 1'b0, 1'b0);
        tick(1);
      end
      d = '0;
      kp = '0;
      for (int i = 0; i < db; i++) begin
        if (b*db + i < fr.size()) begin
          d[8*i +: 8] = fr[b*db + i];
          kp[i] = 1'b1;
        end
      end
      set_in(k, d, kp, 1'b1, (b == nb-1) && !no_last, b == abort_beat);
      tick(1);
    end
    set_in(k, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    for (int k = 0; k < 4; k++) set_in(k, '0, '0, 1'b0, 1'b0, 1'b0);
    areset = 1'b1;
    tick(2);
    areset = 1'b0;
    tick(1);
  endtask

  q_t v13, v13_bad, z60, z59, fa, fb;

  task automatic test_reset();
    do_reset();
    n_cmp++; if (m_tvalid_2 !== 1'b0) begin n_bad++; $display("FAIL reset_m_tvalid: got %b want 0", m_tvalid_2); end
    n_cmp++; if (done_2 !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", done_2); end
    n_cmp++; if (m_tuser_2 !== 1'b0) begin n_bad++; $display("FAIL reset_m_tuser: got %b want 0", m_tuser_2); end
    n_cmp++; if (flen_2 !== 16'd0) begin n_bad++; $display("FAIL reset_frame_len: got %0d want 0", flen_2); end
    n_cmp++; if (gcnt_2 !== 32'd0) begin n_bad++; $display("FAIL reset_good_cnt: got %0d want 0", gcnt_2); end
    n_cmp++; if (bcnt_2 !== 32'd0) begin n_bad++; $display("FAIL reset_bad_cnt: got %0d want 0", bcnt_2); end
  endtask

  task automatic test_db1();
    do_reset();
    send_frame(0, 1, v13, -1, 1'b0, 1'b0);
    tick(2);
    n_cmp++; if (st0.ndone !== 1) begin n_bad++; $display("FAIL db1_done: got %0d want 1", st0.ndone); end
    n_cmp++; if (st0.good !== 1'b1) begin n_bad++; $display("FAIL db1_good: got %b want 1", st0.good); end
    n_cmp++; if (st0.flen !== 16'd13) begin n_bad++; $display("FAIL db1_len: got %0d want 13", st0.flen); end
    n_cmp++; if (gcnt_0 !== 32'd1) begin n_bad++; $display("FAIL db1_good_cnt: got %0d want 1", gcnt_0); end
  endtask

  task automatic test_db4_crc();
    do_reset();
    send_frame(1, 4, v13, -1, 1'b0, 1'b0);
    tick(2);
    n_cmp++; if (st1.good !== 1'b1) begin n_bad++; $display("FAIL db4_good: got %b want 1", st1.good); end
    n_cmp++; if (st1.flen !== 16'd13) begin n_bad++; $display("FAIL db4_len: got %0d want 13", st1.flen); end
    send_frame(1, 4, v13_bad, -1, 1'b0, 1'b0);
    tick(2);
    n_cmp++; if (st1.crc !== 1'b1) begin n_bad++; $display("FAIL db4_crc_err: got %b want 1", st1.crc); end
    n_cmp++; if (st1.tuser !== 1'b1) begin n_bad++; $display("FAIL db4_tuser: got %b want 1", st1.tuser); end
    n_cmp++; if (st1.len !== 1'b0) begin n_bad++; $display("FAIL db4_len_err: got %b want 0", st1.len); end
    n_cmp++; if (bcnt_1 !== 32'd1) begin n_bad++; $display("FAIL db4_bad_cnt: got %0d want 1", bcnt_1); end
    n_cmp++; if (gcnt_1 !== 32'd1) begin n_bad++; $display("FAIL db4_good_cnt: got %0d want 1", gcnt_1); end
  endtask

  task automatic test_keep();
    do_reset();
    set_in(1, 64'h0403_0201, 8'h0F, 1'b1, 1'b0, 1'b0);
    tick(1);
    set_in(1, 64'h0006_0005, 8'h05, 1'b1, 1'b1, 1'b0);
    tick(1);
    set_in(1, '0, '0, 1'b0, 1'b0, 1'b0);
    tick(2);
    n_cmp++; if (st1.keep !== 1'b1) begin n_bad++; $display("FAIL keep_err: got %b want 1", st1.keep); end
    n_cmp++; if (st1.flen !== 16'd6) begin n_bad++; $display("FAIL keep_len: got %0d want 6", st1.flen); end
    n_cmp++; if (st1.good !== 1'b0) begin n_bad++; $display("FAIL keep_good: got %b want 0", st1.good); end
  endtask

  task automatic test_len();
    do_reset();
    send_frame(2, 4, z60, -1, 1'b0, 1'b0);
    tick(2);
    n_cmp++; if (st2.good !== 1'b1) begin n_bad++; $display("FAIL len64_good: got %b want 1", st2.good); end
    n_cmp++; if (st2.flen !== 16'd64) begin n_bad++; $display("FAIL len64_len: got %0d want 64", st2.flen); end
    send_frame(2, 4, z59, -1, 1'b0, 1'b0);
    tick(2);
    n_cmp++; if (st2.len !== 1'b1) begin n_bad++; $display("FAIL len63_len_err: got %b want 1", st2.len); end
    n_cmp++; if (st2.crc !== 1'b0) begin n_bad++; $display("FAIL len63_crc_err: got %b want 0", st2.crc); end
    n_cmp++; if (st2.good !== 1'b0) begin n_bad++; $display("FAIL len63_good: got %b want 0", st2.good); end
    n_cmp++; if (st2.flen !== 16'd63) begin n_bad++; $display("FAIL len63_len: got %0d want 63", st2.flen); end
    n_cmp++; if (bcnt_2 !== 32'd1) begin n_bad++; $display("FAIL len_bad_cnt: got %0d want 1", bcnt_2); end
  endtask

  task automatic test_abort();
    do_reset();
    send_frame(2, 4, z60, 2, 1'b0, 1'b0);
    tick(2);
    n_cmp++; if (st2.abort !== 1'b1) begin n_bad++; $display("FAIL abort_err: got %b want 1", st2.abort); end
    n_cmp++; if (st2.crc !== 1'b0) begin n_bad++; $display("FAIL abort_crc_err: got %b want 0", st2.crc); end
    n_cmp++; if (st2.good !== 1'b0) begin n_bad++; $display("FAIL abort_good: got %b want 0", st2.good); end
    n_cmp++; if (st2.nbytes !== 64) begin n_bad++; $display("FAIL abort_fwd_bytes: got %0d want 64", st2.nbytes); end
    n_cmp++; if (bcnt_2 !== 32'd1) begin n_bad++; $display("FAIL abort_bad_cnt: got %0d want 1", bcnt_2); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_frame(2, 4, fa, -1, 1'b0, 1'b1);
    do_reset();
    send_frame(2, 4, z60, -1, 1'b0, 1'b0);
    tick(2);
    n_cmp++; if (st2.ndone !== 1) begin n_bad++; $display("FAIL rstmid_done: got %0d want 1", st2.ndone); end
    n_cmp++; if (gcnt_2 !== 32'd1) begin n_bad++; $display("FAIL rstmid_good_cnt: got %0d want 1", gcnt_2); end
    n_cmp++; if (bcnt_2 !== 32'd0) begin n_bad++; $display("FAIL rstmid_bad_cnt: got %0d want 0", bcnt_2); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(3, 8, fa, -1, 1'b1, 1'b0);
    send_frame(3, 8, fb, -1, 1'b1, 1'b0);
    tick(3);
    n_cmp++; if (st3.ndone !== 2) begin n_bad++; $display("FAIL b2b_done: got %0d want 2", st3.ndone); end
    n_cmp++; if (gcnt_3 !== 32'd2) begin n_bad++; $display("FAIL b2b_good_cnt: got %0d want 2", gcnt_3); end
    n_cmp++; if (bcnt_3 !== 32'd0) begin n_bad++; $display("FAIL b2b_bad_cnt: got %0d want 0", bcnt_3); end
    n_cmp++; if (st3.flen !== 16'd70) begin n_bad++; $display("FAIL b2b_len: got %0d want 70", st3.flen); end
    n_cmp++; if (st3.nbytes !== 134) begin n_bad++; $display("FAIL b2b_fwd_bytes: got %0d want 134", st3.nbytes); end
  endtask

  initial begin
    // "123456789" with its well-known FCS 26 39 F4 CB
    v13 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    v13_bad = v13;
    v13_bad[5] = 8'h37;
    z60 = {};
    for (int i = 0; i < 60; i++) z60.push_back(8'h00);
    z59 = {};
    for (int i = 0; i < 59; i++) z59.push_back(8'h00);
    z60 = add_fcs(z60);
    z59 = add_fcs(z59);
    fa = {};
    for (int i = 0; i < 60; i++) fa.push_back(8'(i + 1));
    fa = add_fcs(fa);
    fb = {};
    for (int i = 0; i < 66; i++) fb.push_back(8'(i * 7 + 3));
    fb = add_fcs(fb);

    test_reset();
    test_db1();
    test_db4_crc();
    test_keep();
    test_len();
    test_abort();
    test_reset_mid();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
